// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the CPU memory-visit interface.
//   mem_vis_e  - request codes driven by the CPU on mem_vis_signal
//   get_byte   - extracts byte lane k (little-endian) from a 32-bit word
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        READ_INST = 2'b01,
        READ_DATA = 2'b10,
        WRITE     = 2'b11
    } mem_vis_e;

    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        return w[8*k +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: responder side of the CPU memory-visit interface.
// Serialises each word request into four byte accesses on a byte-wide
// synchronous RAM (1-cycle read latency), then pulses mem_vis_finished.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rdy_in            - global ready; low freezes the block
//   mem_vis_signal    - request code (mem_vis_e)
//   mem_addr          - byte address of the word (no alignment needed)
//   mem_write_data    - store data for WRITE
//   instruction       - fetched word (READ_INST)
//   mem_read_data     - loaded word (READ_DATA)
//   mem_vis_finished  - one-cycle completion pulse
//   ram_din           - RAM read byte, valid the cycle after its address
//   ram_dout, ram_addr, ram_wr - RAM write byte, byte address, write enable
module mem_ctrl #(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic [1:0]            mem_vis_signal,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [LEN-1:0]        mem_write_data,
    output logic [LEN-1:0]        instruction,
    output logic [LEN-1:0]        mem_read_data,
    output logic                  mem_vis_finished,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr
);
    import mem_ctrl_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                state_q;
    logic [2:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [LEN-1:0]        wdata_q;
    logic [LEN-1:0]        word_q;
    logic [LEN-1:0]        instr_q;
    logic [LEN-1:0]        rdata_q;
    logic [7:0]            ram_dout_q;
    logic                  ram_wr_q;
    logic                  fin_q;
    logic                  is_inst_q;
    logic                  restart_q;

    mem_vis_e              req_d;
    logic [ADDR_WIDTH-1:0] ram_addr_inc_d;
    logic [LEN-1:0]        word_shift_d;
    logic [7:0]            next_byte_d;

    always_comb begin
        req_d          = mem_vis_e'(mem_vis_signal);
        // Natural wrap at 2^ADDR_WIDTH.
        ram_addr_inc_d = ram_addr_q + ADDR_WIDTH'(1);
        // Little-endian assembly: each new byte enters at the top and the
        // fourth shift leaves byte0 in [7:0].
        word_shift_d   = {ram_din, word_q[LEN-1:8]};
        next_byte_d    = get_byte(wdata_q, cnt_q[1:0] + 2'd1);
    end

    // READ: cnt_q runs 0..4. Counts 0..3 present addr+k; counts 1..4 capture
    // the byte addressed in the previous cycle.
    // WRITE: cnt_q runs 0..3, one byte written per cycle.
    // A stall in WRITE cannot raise the registered ram_wr in the first ready
    // cycle, so restart_q spends that cycle re-arming byte 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            instr_q    <= '0;
            rdata_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            fin_q      <= 1'b0;
            is_inst_q  <= 1'b0;
            restart_q  <= 1'b0;
        end else if (!rdy_in) begin
            ram_wr_q <= 1'b0;
            fin_q    <= 1'b0;
            if (state_q == S_READ || state_q == S_WRITE) begin
                cnt_q      <= '0;
                ram_addr_q <= addr_q;
                ram_dout_q <= get_byte(wdata_q, 2'd0);
                restart_q  <= (state_q == S_WRITE);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_d != MEM_NOP) begin
                        addr_q     <= mem_addr;
                        wdata_q    <= mem_write_data;
                        is_inst_q  <= (req_d == READ_INST);
                        ram_addr_q <= mem_addr;
                        cnt_q      <= '0;
                        if (req_d == WRITE) begin
                            state_q    <= S_WRITE;
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= mem_write_data[7:0];
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q != 3'd0) begin
                        word_q <= word_shift_d;
                    end
                    if (cnt_q < 3'd3) begin
                        ram_addr_q <= ram_addr_inc_d;
                    end
                    if (cnt_q == 3'd4) begin
                        if (is_inst_q) begin
                            instr_q <= word_shift_d;
                        end else begin
                            rdata_q <= word_shift_d;
                        end
                        fin_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_WRITE: begin
                    if (restart_q) begin
                        restart_q <= 1'b0;
                        ram_wr_q  <= 1'b1;
                    end else if (cnt_q == 3'd3) begin
                        ram_wr_q <= 1'b0;
                        fin_q    <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q      <= cnt_q + 3'd1;
                        ram_addr_q <= ram_addr_inc_d;
                        ram_dout_q <= next_byte_d;
                    end
                end
                S_DONE: begin
                    // fin_q low here means the pulse was suppressed by a
                    // stall; re-issue it before returning to idle.
                    if (fin_q) begin
                        fin_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        fin_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instruction      = instr_q;
    assign mem_read_data    = rdata_q;
    assign mem_vis_finished = fin_q;
    assign ram_dout         = ram_dout_q;
    assign ram_addr         = ram_addr_q;
    assign ram_wr           = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a
// 1-cycle-latency byte RAM model and a log of RAM write cycles.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy_in;
    logic [1:0]  mem_vis_signal;
    logic [16:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] instruction;
    logic [31:0] mem_read_data;
    logic        mem_vis_finished;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [16:0] ram_addr;
    logic        ram_wr;

    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [0:(1<<17)-1];
    logic [24:0] wlog [$];

    mem_ctrl #(.LEN(32), .ADDR_WIDTH(17)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy_in           (rdy_in),
        .mem_vis_signal   (mem_vis_signal),
        .mem_addr         (mem_addr),
        .mem_write_data   (mem_write_data),
        .instruction      (instruction),
        .mem_read_data    (mem_read_data),
        .mem_vis_finished (mem_vis_finished),
        .ram_din          (ram_din),
        .ram_dout         (ram_dout),
        .ram_addr         (ram_addr),
        .ram_wr           (ram_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr === 1'b1) begin
            mem[ram_addr] <= ram_dout;
            wlog.push_back({ram_addr, ram_dout});
        end
        ram_din <= mem[ram_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait (bounded) for finished, check latency, then
    // step into the idle cycle that follows DONE.
    task automatic do_access(input logic [1:0] kind, input logic [16:0] a,
                             input logic [31:0] d, input int exp_lat, input string tag);
        int n;
        mem_vis_signal = kind;
        mem_addr       = a;
        mem_write_data = d;
        tick;
        mem_vis_signal = 2'b00;
        n = 1;
        while (mem_vis_finished !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, exp_lat);
        tick;
        check({tag, "_pulse_end"}, {31'd0, mem_vis_finished}, 32'd0);
    endtask

    initial begin
        int pulses;
        int last_pulse;
        logic prev_fin;

        for (int i = 0; i < (1 << 17); i++) mem[i] = 8'h00;
        mem[17'h100] = 8'h13; mem[17'h101] = 8'h05; mem[17'h102] = 8'hA0; mem[17'h103] = 8'h00;
        mem[17'h400] = 8'h21; mem[17'h401] = 8'h43; mem[17'h402] = 8'h65; mem[17'h403] = 8'h87;
        mem[17'h300] = 8'h01; mem[17'h301] = 8'h02; mem[17'h302] = 8'h03; mem[17'h303] = 8'h04;

        rst = 1'b1; rdy_in = 1'b1; mem_vis_signal = 2'b00;
        mem_addr = '0; mem_write_data = '0;
        tick; tick;
        check("rst_instruction", instruction, 32'h0);
        check("rst_read_data", mem_read_data, 32'h0);
        check("rst_finished", {31'd0, mem_vis_finished}, 32'd0);
        check("rst_ram_addr", {15'd0, ram_addr}, 32'h0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'h0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        rst = 1'b0;
        tick;

        // 1. Instruction fetch with per-cycle address checks.
        mem_vis_signal = 2'b01; mem_addr = 17'h100;
        tick;
        mem_vis_signal = 2'b00;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fetch_addr%0d", k), {15'd0, ram_addr}, 32'h100 + k);
            check($sformatf("fetch_wr%0d", k), {31'd0, ram_wr}, 32'd0);
            tick;
        end
        check("fetch_fin_t5", {31'd0, mem_vis_finished}, 32'd0);
        tick;
        check("fetch_fin_t6", {31'd0, mem_vis_finished}, 32'd1);
        check("fetch_instr", instruction, 32'h00A00513);
        check("fetch_rdata_hold", mem_read_data, 32'h0);
        tick;
        check("fetch_fin_t7", {31'd0, mem_vis_finished}, 32'd0);

        // 2. Store then load.
        wlog.delete();
        do_access(2'b11, 17'h200, 32'hDEADBEEF, 5, "store");
        check("store_nwr", wlog.size(), 4);
        check("store_b0", {7'd0, wlog[0]}, {7'd0, 17'h200, 8'hEF});
        check("store_b1", {7'd0, wlog[1]}, {7'd0, 17'h201, 8'hBE});
        check("store_b2", {7'd0, wlog[2]}, {7'd0, 17'h202, 8'hAD});
        check("store_b3", {7'd0, wlog[3]}, {7'd0, 17'h203, 8'hDE});
        do_access(2'b10, 17'h200, 32'h0, 6, "load");
        check("load_rdata", mem_read_data, 32'hDEADBEEF);
        check("load_instr_hold", instruction, 32'h00A00513);

        // 3. Address wrap on a write.
        wlog.delete();
        do_access(2'b11, 17'h1FFFE, 32'h11223344, 5, "wrap");
        check("wrap_nwr", wlog.size(), 4);
        check("wrap_b0", {7'd0, wlog[0]}, {7'd0, 17'h1FFFE, 8'h44});
        check("wrap_b1", {7'd0, wlog[1]}, {7'd0, 17'h1FFFF, 8'h33});
        check("wrap_b2", {7'd0, wlog[2]}, {7'd0, 17'h00000, 8'h22});
        check("wrap_b3", {7'd0, wlog[3]}, {7'd0, 17'h00001, 8'h11});

        // 4. Stall for 3 cycles while byte 2 is addressed; read restarts.
        wlog.delete();
        mem_vis_signal = 2'b10; mem_addr = 17'h400;
        tick;
        mem_vis_signal = 2'b00;
        tick; tick;
        check("stall_addr_b2", {15'd0, ram_addr}, 32'h402);
        rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            check($sformatf("stall_fin%0d", k), {31'd0, mem_vis_finished}, 32'd0);
            check($sformatf("stall_wr%0d", k), {31'd0, ram_wr}, 32'd0);
        end
        rdy_in = 1'b1;
        check("stall_restart_addr", {15'd0, ram_addr}, 32'h400);
        begin
            int n;
            n = 6;
            while (mem_vis_finished !== 1'b1 && n < 30) begin
                tick;
                n++;
            end
            check("stall_lat", n, 11);
        end
        check("stall_rdata", mem_read_data, 32'h87654321);
        tick;
        check("stall_pulse_end", {31'd0, mem_vis_finished}, 32'd0);
        check("stall_no_writes", wlog.size(), 0);

        // 5. Reset in the middle of a write, after byte 1.
        mem_vis_signal = 2'b11; mem_addr = 17'h500; mem_write_data = 32'hCAFEF00D;
        tick;
        mem_vis_signal = 2'b00;
        tick;
        check("rstw_addr_b1", {15'd0, ram_addr}, 32'h501);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rstw_wr", {31'd0, ram_wr}, 32'd0);
        check("rstw_addr", {15'd0, ram_addr}, 32'h0);
        check("rstw_instr", instruction, 32'h0);
        check("rstw_rdata", mem_read_data, 32'h0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_vis_finished === 1'b1) pulses++;
            tick;
        end
        check("rstw_no_fin", pulses, 0);
        check("rstw_mem", {mem[17'h503], mem[17'h502], mem[17'h501], mem[17'h500]}, 32'h0000F00D);
        do_access(2'b10, 17'h500, 32'h0, 6, "rstw_load");
        check("rstw_load_rdata", mem_read_data, 32'h0000F00D);

        // 6. Request held continuously: one pulse every 7 cycles.
        mem_vis_signal = 2'b10; mem_addr = 17'h300;
        pulses = 0; last_pulse = 0; prev_fin = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            tick;
            if (mem_vis_finished === 1'b1) begin
                check("held_no_double", {31'd0, prev_fin}, 32'd0);
                if (pulses == 0) check("held_first", c, 6);
                else check("held_gap", c - last_pulse, 7);
                pulses++;
                last_pulse = c;
            end
            prev_fin = mem_vis_finished;
            if (c == 34) mem_vis_signal = 2'b00;
        end
        check("held_pulses", pulses, 5);
        check("held_rdata", mem_read_data, 32'h04030201);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
